// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stall/flush/redirect controls for the pipeline front end
interface pipe_hazard_ctrl_if #(parameter int XLEN = 32);
  logic            ex_jmp;
  logic [XLEN-1:0] ex_jmp_target;
  logic            ex_busy;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic            imem_ready;
  logic            pc_stall;
  logic            pc_redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            if_id_stall;
  logic            if_id_flush;
  logic            id_ex_stall;
  logic            id_ex_flush;
  logic [31:0]     stall_cycles;
  modport master (
    input  ex_jmp, ex_jmp_target, ex_busy, ex_mem_read, ex_rd, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, imem_ready,
    output pc_stall, pc_redirect, redirect_addr, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, stall_cycles
  );
  modport slave (
    output ex_jmp, ex_jmp_target, ex_busy, ex_mem_read, ex_rd, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, imem_ready,
    input  pc_stall, pc_redirect, redirect_addr, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect sequencer for the IF/ID and ID/EX registers
module pipe_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  pipe_hazard_ctrl_if.master  bus
);
  typedef enum logic [1:0] {RUN, FLUSH, BUSY} state_t;
  state_t          state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [31:0]     scnt_q, scnt_d;
  logic            load_use;
  logic            pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic [XLEN-1:0] redirect_addr;
  assign load_use = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                    ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
                     (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
  // priority-ordered control decode: reset > jump > flush window > busy > load-use > fetch miss
  always_comb begin
    pc_stall      = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = '0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    state_d       = RUN;
    fcnt_d        = 3'd0;
    if (rst) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (bus.ex_jmp) begin
      pc_redirect   = 1'b1;
      redirect_addr = bus.ex_jmp_target;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      state_d       = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      fcnt_d        = 3'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fcnt_d      = fcnt_q - 3'd1;
      state_d     = fcnt_q <= 3'd1 ? RUN : FLUSH;
    end else if (bus.ex_busy) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
      state_d     = BUSY;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!bus.imem_ready) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
    scnt_d = rst ? 32'd0 : scnt_q + {31'd0, pc_stall};
  end
  // state, flush countdown and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      scnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end
  assign bus.pc_stall      = pc_stall;
  assign bus.pc_redirect   = pc_redirect;
  assign bus.redirect_addr = redirect_addr;
  assign bus.if_id_stall   = if_id_stall;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_stall   = id_ex_stall;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.stall_cycles  = scnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for the hazard sequencer
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_hazard_ctrl_if #(.XLEN(32)) bus ();
  pipe_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RST  = 6'b100101;
  localparam logic [5:0] LU   = 6'b101001;
  localparam logic [5:0] JMP  = 6'b010101;
  localparam logic [5:0] FL   = 6'b000101;
  localparam logic [5:0] BSY  = 6'b101010;
  localparam logic [5:0] IMR  = 6'b100100;
  typedef struct {
    string       tag;
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] s;
  } exp_t;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_scnt = 32'd0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input string tag, input logic r, input logic jmp, input logic [31:0] tgt,
                       input logic busy, input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2, input logic imr,
                       input logic [5:0] e, input logic [31:0] ea);
    rst = r;
    bus.ex_jmp = jmp;
    bus.ex_jmp_target = tgt;
    bus.ex_busy = busy;
    bus.ex_mem_read = mr;
    bus.ex_rd = rd;
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.imem_ready = imr;
    sb.push_back('{tag, e, ea, exp_scnt});
    exp_scnt = r ? 32'd0 : exp_scnt + {31'd0, e[5]};
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t t;
      t = sb.pop_front();
      check({t.tag, ".ctrl"}, 64'({bus.pc_stall, bus.pc_redirect, bus.if_id_stall,
                                   bus.if_id_flush, bus.id_ex_stall, bus.id_ex_flush}), 64'(t.c));
      check({t.tag, ".addr"}, 64'(bus.redirect_addr), 64'(t.a));
      check({t.tag, ".scnt"}, 64'(bus.stall_cycles), 64'(t.s));
    end
  end
  initial begin
    bus.ex_jmp = 0; bus.ex_jmp_target = 0; bus.ex_busy = 0; bus.ex_mem_read = 0;
    bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0;
    bus.id_rs2_used = 0; bus.imem_ready = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0);
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    drive("lu_rs2", 0, 0, 0, 0, 1, 5, 0, 5, 0, 1, 1, LU, 0);
    drive("lu_clr", 0, 0, 0, 0, 0, 5, 0, 5, 0, 1, 1, NONE, 0);
    drive("lu_rd0", 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, NONE, 0);
    drive("lu_rs1", 0, 0, 0, 0, 1, 7, 7, 0, 1, 0, 1, LU, 0);
    drive("lu_unused", 0, 0, 0, 0, 1, 7, 7, 7, 0, 0, 1, NONE, 0);
    drive("jmp1", 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, JMP, 32'h100);
    drive("fl1a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL, 0);
    drive("fl1b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL, 0);
    drive("run1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    drive("jmp2", 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, JMP, 32'h100);
    drive("jmp2b", 0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, JMP, 32'h200);
    drive("fl2a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL, 0);
    drive("fl2b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL, 0);
    drive("run2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    for (int i = 0; i < 4; i++) drive("busy", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, BSY, 0);
    drive("busy_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    drive("bj_b1", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, BSY, 0);
    drive("bj_b2", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, BSY, 0);
    drive("bj_jmp", 0, 1, 32'h300, 1, 0, 0, 0, 0, 0, 0, 1, JMP, 32'h300);
    drive("bj_fla", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, FL, 0);
    drive("bj_flb", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, FL, 0);
    drive("bj_busy", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, BSY, 0);
    drive("bj_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    drive("lu_imem", 0, 0, 0, 0, 1, 3, 3, 0, 1, 0, 0, LU, 0);
    drive("imem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMR, 0);
    drive("imem_ok", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    drive("rf_jmp", 0, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1, JMP, 32'h400);
    drive("rf_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0);
    drive("rf_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    drive("rf_run2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    drive("rf_imem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMR, 0);
    drive("tail", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0);
    @(posedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
